// File: rtl/bpsk_tx_ctrl.sv
// BPSK transmit sequencer: preamble + MSB-first byte serializer, one
// signed symbol per SPS carrier samples, with carrier gating and phase sync.
module bpsk_tx_ctrl #(
  parameter int BWIDTH  = 2,
  parameter int SPS     = 16,
  parameter int PRE_LEN = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [7:0]               frame_len,
  input  logic [7:0]               din,
  input  logic                     din_valid,
  output logic                     din_ready,
  output logic signed [BWIDTH-1:0] base_sig,
  output logic                     carrier_en,
  output logic                     carrier_sync,
  output logic                     busy,
  output logic                     done,
  output logic                     underrun
);

  localparam int SW = (SPS > 1) ? $clog2(SPS) : 1;
  localparam int YW = $clog2((PRE_LEN > 8) ? PRE_LEN : 8);
  localparam logic [BWIDTH-1:0] POS = BWIDTH'(1);
  localparam logic [BWIDTH-1:0] NEG = {BWIDTH{1'b1}};

  typedef enum logic [1:0] {IDLE, PRE, DATA} state_t;

  state_t        state_q, state_d;
  logic [SW-1:0] samp_cnt;
  logic [YW-1:0] sym_cnt;
  logic [7:0]    byte_cnt;
  logic [7:0]    flen;
  // Bits still to be sent in the current byte; the bit on air lives in base_sig.
  logic [6:0]    sreg;

  logic sym_end, pre_last, bit_last, fetch, finish;

  assign sym_end  = (samp_cnt == SW'(SPS - 1));
  assign pre_last = (sym_cnt == YW'(PRE_LEN - 1));
  assign bit_last = (sym_cnt == YW'(7));

  // Next state plus fetch/finish decode; fetch depends only on state/counters.
  always_comb begin
    state_d = state_q;
    fetch   = 1'b0;
    finish  = 1'b0;
    case (state_q)
      IDLE: if (start) state_d = PRE;
      PRE:  if (sym_end && pre_last) begin
              if (flen == 8'd0) finish = 1'b1;
              else              fetch  = 1'b1;
            end
      DATA: if (sym_end && bit_last) begin
              if (byte_cnt == flen) finish = 1'b1;
              else                  fetch  = 1'b1;
            end
      default: state_d = IDLE;
    endcase
    if (finish) state_d = IDLE;
    if (fetch)  state_d = din_valid ? DATA : IDLE;
  end

  assign din_ready = fetch;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Counters, shift register and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      samp_cnt     <= '0;
      sym_cnt      <= '0;
      byte_cnt     <= '0;
      flen         <= '0;
      sreg         <= '0;
      base_sig     <= '0;
      busy         <= 1'b0;
      carrier_en   <= 1'b0;
      carrier_sync <= 1'b0;
      done         <= 1'b0;
      underrun     <= 1'b0;
    end else begin
      carrier_sync <= 1'b0;
      done         <= 1'b0;
      underrun     <= 1'b0;
      if (state_q == IDLE) begin
        if (start) begin
          flen         <= frame_len;
          busy         <= 1'b1;
          carrier_en   <= 1'b1;
          carrier_sync <= 1'b1;
          base_sig     <= POS;
          samp_cnt     <= '0;
          sym_cnt      <= '0;
          byte_cnt     <= '0;
        end
      end else begin
        samp_cnt <= sym_end ? '0 : samp_cnt + SW'(1);
        if (finish || (fetch && !din_valid)) begin
          // Frame over (normally or starved): drop to idle at once.
          busy       <= 1'b0;
          carrier_en <= 1'b0;
          base_sig   <= '0;
          samp_cnt   <= '0;
          sym_cnt    <= '0;
          byte_cnt   <= '0;
          done       <= finish;
          underrun   <= fetch;
        end else if (fetch) begin
          sreg     <= din[6:0];
          base_sig <= din[7] ? POS : NEG;
          byte_cnt <= byte_cnt + 8'd1;
          sym_cnt  <= '0;
        end else if (sym_end) begin
          sym_cnt <= sym_cnt + YW'(1);
          if (state_q == PRE) begin
            // Next preamble index is odd when the current one is even.
            base_sig <= sym_cnt[0] ? POS : NEG;
          end else begin
            base_sig <= sreg[6] ? POS : NEG;
            sreg     <= {sreg[5:0], 1'b0};
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_bpsk_tx_ctrl.sv
// Self-checking bench for bpsk_tx_ctrl against a cycle-index reference model.
module tb_bpsk_tx_ctrl;
  localparam int BW  = 2;
  localparam int SPS = 4;
  localparam int PRE = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic [7:0] frame_len = '0;
  logic [7:0] din = '0;
  logic din_valid = 1'b0;
  logic din_ready;
  logic signed [BW-1:0] base_sig;
  logic carrier_en, carrier_sync, busy, done, underrun;

  int checks = 0;
  int failures = 0;
  logic [7:0] bytes [256];
  bit chain = 1'b0;
  logic [7:0] chain_len = '0;

  bpsk_tx_ctrl #(.BWIDTH(BW), .SPS(SPS), .PRE_LEN(PRE)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .frame_len(frame_len),
    .din(din), .din_valid(din_valid), .din_ready(din_ready),
    .base_sig(base_sig), .carrier_en(carrier_en), .carrier_sync(carrier_sync),
    .busy(busy), .done(done), .underrun(underrun)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] observed();
    return {busy, carrier_en, carrier_sync, din_ready, done, underrun, base_sig};
  endfunction

  // Cycle c (0 = first busy sample) ends a fetch for byte k < flen when the
  // sample count through c equals (PRE + 8k) symbols.
  function automatic bit is_fetch(int c, int flen);
    int n, s;
    n = c + 1;
    if (n % SPS != 0) return 1'b0;
    s = n / SPS;
    if (s < PRE) return 1'b0;
    if ((s - PRE) % 8 != 0) return 1'b0;
    return ((s - PRE) / 8) < flen;
  endfunction

  // Expected {busy,carrier_en,carrier_sync,din_ready,done,underrun,base_sig}.
  function automatic logic [7:0] expect_out(int c, int act, int flen, bit drop);
    int s, bp;
    logic [7:0] b;
    logic [1:0] sym;
    if (c < act) begin
      s = c / SPS;
      if (s < PRE) sym = (s % 2 == 0) ? 2'b01 : 2'b11;
      else begin
        bp  = s - PRE;
        b   = bytes[bp / 8];
        sym = b[7 - (bp % 8)] ? 2'b01 : 2'b11;
      end
      return {1'b1, 1'b1, (c == 0), is_fetch(c, flen), 1'b0, 1'b0, sym};
    end
    if (c == act) return {4'b0000, !drop, drop, 2'b00};
    return 8'h00;
  endfunction

  // Runs one frame and compares every output on every cycle.
  task automatic run_frame(input int flen, input int drop_idx, input bit prestarted,
                           input int mid_start);
    int act, nextk;
    bit drop;
    logic [7:0] exp, obs;
    drop  = (drop_idx >= 0) && (drop_idx < flen);
    act   = drop ? (PRE + 8 * drop_idx) * SPS : (PRE + 8 * flen) * SPS;
    nextk = 0;
    if (!prestarted) begin
      frame_len = 8'(flen);
      start     = 1'b1;
    end
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 0; c <= act + 2; c++) begin
      if (c > 0) begin @(posedge clk); #1; end
      din       = bytes[nextk];
      din_valid = !(drop && nextk == drop_idx);
      start     = (c == mid_start);
      if (c == 1 || c == mid_start) frame_len = 8'($urandom);
      exp = expect_out(c, act, flen, drop);
      obs = observed();
      checks++;
      if (obs !== exp) begin
        failures++;
        $display("FAIL frame len=%0d cycle=%0d got=%b want=%b", flen, c, obs, exp);
      end
      if (exp[4]) nextk++;
      if (c == act && chain) begin
        start     = 1'b1;
        frame_len = chain_len;
        return;
      end
    end
    start     = 1'b0;
    din_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 5; i++) begin
      start = 1'($urandom); din_valid = 1'($urandom);
      din = 8'($urandom); frame_len = 8'($urandom);
      @(posedge clk); #1;
      checks++;
      if (observed() !== 8'h00) begin
        failures++;
        $display("FAIL reset_hold got=%b want=%b", observed(), 8'h00);
      end
    end
    start = 1'b0; din_valid = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if (observed() !== 8'h00) begin
        failures++;
        $display("FAIL reset_release got=%b want=%b", observed(), 8'h00);
      end
    end
  endtask

  task automatic test_basic();
    bytes[0] = 8'hA5;
    run_frame(1, -1, 1'b0, -1);
  endtask

  task automatic test_len0();
    run_frame(0, -1, 1'b0, -1);
  endtask

  task automatic test_back_to_back();
    bytes[0] = 8'hFF; bytes[1] = 8'h00; bytes[2] = 8'h81;
    chain = 1'b1; chain_len = 8'd1;
    run_frame(3, -1, 1'b0, -1);
    chain = 1'b0;
    bytes[0] = 8'($urandom);
    run_frame(1, -1, 1'b1, -1);
  endtask

  task automatic test_underrun();
    bytes[0] = 8'($urandom); bytes[1] = 8'($urandom);
    run_frame(2, 1, 1'b0, -1);
  endtask

  task automatic test_start_busy();
    bytes[0] = 8'($urandom); bytes[1] = 8'($urandom);
    run_frame(2, -1, 1'b0, 20);
  endtask

  task automatic test_reset_mid();
    frame_len = 8'd2; start = 1'b1;
    din = 8'($urandom); din_valid = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (PRE * SPS + 6) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (observed() !== 8'h00) begin
      failures++;
      $display("FAIL reset_mid_immediate got=%b want=%b", observed(), 8'h00);
    end
    @(posedge clk); #1;
    checks++;
    if (observed() !== 8'h00) begin
      failures++;
      $display("FAIL reset_mid_held got=%b want=%b", observed(), 8'h00);
    end
    rst_n = 1'b1; din_valid = 1'b0;
    @(posedge clk); #1;
    bytes[0] = 8'($urandom);
    run_frame(1, -1, 1'b0, -1);
  endtask

  task automatic test_random();
    int flen, drop_idx;
    for (int f = 0; f < 6; f++) begin
      flen = $urandom_range(0, 3);
      for (int i = 0; i < 4; i++) bytes[i] = 8'($urandom);
      drop_idx = -1;
      if (flen > 0 && $urandom_range(0, 2) == 0) drop_idx = $urandom_range(0, flen - 1);
      run_frame(flen, drop_idx, 1'b0, -1);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) bytes[i] = '0;
    test_reset();
    test_basic();
    test_len0();
    test_back_to_back();
    test_underrun();
    test_start_busy();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
